// File: rtl/snitch_dma_event_monitor.sv
// Per-channel DMA event monitor: turns AXI and data-buffer handshakes of one
// backend channel into registered one-cycle event strobes for perf counters.
module snitch_dma_event_monitor #(
  parameter int unsigned DataWidth      = 512,
  parameter int unsigned MaxOutstanding = 16
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic                                  clear_i,
  input  logic                                  aw_valid_i,
  input  logic                                  aw_ready_i,
  input  logic [7:0]                            aw_len_i,
  input  logic [2:0]                            aw_size_i,
  input  logic                                  ar_valid_i,
  input  logic                                  ar_ready_i,
  input  logic [7:0]                            ar_len_i,
  input  logic [2:0]                            ar_size_i,
  input  logic                                  w_valid_i,
  input  logic                                  w_ready_i,
  input  logic [DataWidth/8-1:0]                w_strb_i,
  input  logic                                  r_valid_i,
  input  logic                                  r_ready_i,
  input  logic                                  r_last_i,
  input  logic                                  b_valid_i,
  input  logic                                  b_ready_i,
  input  logic                                  buf_w_valid_i,
  input  logic                                  buf_w_ready_i,
  input  logic                                  buf_r_valid_i,
  input  logic                                  buf_r_ready_i,
  input  logic                                  backend_busy_i,
  output logic                                  aw_stall_o,
  output logic                                  ar_stall_o,
  output logic                                  w_stall_o,
  output logic                                  r_stall_o,
  output logic                                  buf_w_stall_o,
  output logic                                  buf_r_stall_o,
  output logic                                  aw_done_o,
  output logic                                  ar_done_o,
  output logic                                  w_done_o,
  output logic                                  r_done_o,
  output logic                                  b_done_o,
  output logic [7:0]                            aw_len_o,
  output logic [7:0]                            ar_len_o,
  output logic [2:0]                            aw_size_o,
  output logic [2:0]                            ar_size_o,
  output logic [$clog2(DataWidth/8):0]          num_bytes_written_o,
  output logic                                  dma_busy_o,
  output logic                                  err_o
);

  localparam int unsigned StrbWidth = DataWidth / 8;
  localparam int unsigned NbWidth   = $clog2(StrbWidth) + 1;
  localparam int unsigned CntWidth  = $clog2(MaxOutstanding + 1);

  function automatic logic [NbWidth-1:0] popcount(input logic [StrbWidth-1:0] strb);
    logic [NbWidth-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < StrbWidth; i++) begin
      cnt = cnt + {{(NbWidth-1){1'b0}}, strb[i]};
    end
    return cnt;
  endfunction

  // Returns {limit_error, next_count}; simultaneous inc/dec cancels out.
  function automatic logic [CntWidth:0] cnt_update(input logic [CntWidth-1:0] cnt,
                                                   input logic inc, input logic dec);
    logic [CntWidth:0] res;
    res = {1'b0, cnt};
    if (inc && !dec) begin
      if (cnt == CntWidth'(MaxOutstanding)) res = {1'b1, cnt};
      else                                  res = {1'b0, cnt + CntWidth'(1)};
    end else if (dec && !inc) begin
      if (cnt == '0) res = {1'b1, cnt};
      else           res = {1'b0, cnt - CntWidth'(1)};
    end else begin
      res = {1'b0, cnt};
    end
    return res;
  endfunction

  logic                aw_hs_s, ar_hs_s, w_hs_s, r_hs_s, b_hs_s;
  logic [CntWidth-1:0] wr_cnt_r, rd_cnt_r, wr_cnt_next_s, rd_cnt_next_s;
  logic [CntWidth:0]   wr_upd_s, rd_upd_s;
  logic                err_next_s;

  assign aw_hs_s = aw_valid_i & aw_ready_i;
  assign ar_hs_s = ar_valid_i & ar_ready_i;
  assign w_hs_s  = w_valid_i  & w_ready_i;
  assign r_hs_s  = r_valid_i  & r_ready_i;
  assign b_hs_s  = b_valid_i  & b_ready_i;

  // Outstanding-transaction accounting; clear overrides same-cycle handshakes.
  always_comb begin
    wr_upd_s      = cnt_update(wr_cnt_r, aw_hs_s, b_hs_s);
    rd_upd_s      = cnt_update(rd_cnt_r, ar_hs_s, r_hs_s & r_last_i);
    wr_cnt_next_s = wr_cnt_r;
    rd_cnt_next_s = rd_cnt_r;
    err_next_s    = err_o;
    if (clear_i) begin
      wr_cnt_next_s = '0;
      rd_cnt_next_s = '0;
      err_next_s    = 1'b0;
    end else begin
      wr_cnt_next_s = wr_upd_s[CntWidth-1:0];
      rd_cnt_next_s = rd_upd_s[CntWidth-1:0];
      err_next_s    = err_o | wr_upd_s[CntWidth] | rd_upd_s[CntWidth];
    end
  end

  // Output and counter registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_cnt_r            <= '0;
      rd_cnt_r            <= '0;
      err_o               <= 1'b0;
      aw_stall_o          <= 1'b0;
      ar_stall_o          <= 1'b0;
      w_stall_o           <= 1'b0;
      r_stall_o           <= 1'b0;
      buf_w_stall_o       <= 1'b0;
      buf_r_stall_o       <= 1'b0;
      aw_done_o           <= 1'b0;
      ar_done_o           <= 1'b0;
      w_done_o            <= 1'b0;
      r_done_o            <= 1'b0;
      b_done_o            <= 1'b0;
      aw_len_o            <= 8'd0;
      ar_len_o            <= 8'd0;
      aw_size_o           <= 3'd0;
      ar_size_o           <= 3'd0;
      num_bytes_written_o <= '0;
      dma_busy_o          <= 1'b0;
    end else begin
      wr_cnt_r            <= wr_cnt_next_s;
      rd_cnt_r            <= rd_cnt_next_s;
      err_o               <= err_next_s;
      aw_stall_o          <= aw_valid_i & ~aw_ready_i;
      ar_stall_o          <= ar_valid_i & ~ar_ready_i;
      w_stall_o           <= w_valid_i & ~w_ready_i;
      r_stall_o           <= r_valid_i & ~r_ready_i;
      buf_w_stall_o       <= buf_w_valid_i & ~buf_w_ready_i;
      buf_r_stall_o       <= buf_r_valid_i & ~buf_r_ready_i;
      aw_done_o           <= aw_hs_s;
      ar_done_o           <= ar_hs_s;
      w_done_o            <= w_hs_s;
      r_done_o            <= r_hs_s;
      b_done_o            <= b_hs_s;
      aw_len_o            <= aw_hs_s ? aw_len_i  : 8'd0;
      ar_len_o            <= ar_hs_s ? ar_len_i  : 8'd0;
      aw_size_o           <= aw_hs_s ? aw_size_i : 3'd0;
      ar_size_o           <= ar_hs_s ? ar_size_i : 3'd0;
      num_bytes_written_o <= w_hs_s ? popcount(w_strb_i) : '0;
      dma_busy_o          <= backend_busy_i | (wr_cnt_next_s != '0) | (rd_cnt_next_s != '0);
    end
  end

endmodule

// File: tb/tb_snitch_dma_event_monitor.sv
// Directed self-checking bench for snitch_dma_event_monitor (DataWidth=512).
module tb_snitch_dma_event_monitor;

  logic        clk = 1'b0;
  logic        rst, clear;
  logic        aw_valid, aw_ready, ar_valid, ar_ready, w_valid, w_ready;
  logic [7:0]  aw_len, ar_len;
  logic [2:0]  aw_size, ar_size;
  logic [63:0] w_strb;
  logic        r_valid, r_ready, r_last, b_valid, b_ready;
  logic        buf_w_valid, buf_w_ready, buf_r_valid, buf_r_ready, backend_busy;
  logic        aw_stall, ar_stall, w_stall, r_stall, buf_w_stall, buf_r_stall;
  logic        aw_done, ar_done, w_done, r_done, b_done;
  logic [7:0]  aw_len_q, ar_len_q;
  logic [2:0]  aw_size_q, ar_size_q;
  logic [6:0]  nbw;
  logic        dma_busy, err;

  int checks = 0;
  int errors = 0;

  snitch_dma_event_monitor #(.DataWidth(512), .MaxOutstanding(16)) dut (
    .clk_i(clk), .rst_i(rst), .clear_i(clear),
    .aw_valid_i(aw_valid), .aw_ready_i(aw_ready), .aw_len_i(aw_len), .aw_size_i(aw_size),
    .ar_valid_i(ar_valid), .ar_ready_i(ar_ready), .ar_len_i(ar_len), .ar_size_i(ar_size),
    .w_valid_i(w_valid), .w_ready_i(w_ready), .w_strb_i(w_strb),
    .r_valid_i(r_valid), .r_ready_i(r_ready), .r_last_i(r_last),
    .b_valid_i(b_valid), .b_ready_i(b_ready),
    .buf_w_valid_i(buf_w_valid), .buf_w_ready_i(buf_w_ready),
    .buf_r_valid_i(buf_r_valid), .buf_r_ready_i(buf_r_ready),
    .backend_busy_i(backend_busy),
    .aw_stall_o(aw_stall), .ar_stall_o(ar_stall), .w_stall_o(w_stall), .r_stall_o(r_stall),
    .buf_w_stall_o(buf_w_stall), .buf_r_stall_o(buf_r_stall),
    .aw_done_o(aw_done), .ar_done_o(ar_done), .w_done_o(w_done), .r_done_o(r_done),
    .b_done_o(b_done),
    .aw_len_o(aw_len_q), .ar_len_o(ar_len_q), .aw_size_o(aw_size_q), .ar_size_o(ar_size_q),
    .num_bytes_written_o(nbw), .dma_busy_o(dma_busy), .err_o(err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    clear = 1'b0; aw_valid = 1'b0; aw_ready = 1'b0; aw_len = 8'd0; aw_size = 3'd0;
    ar_valid = 1'b0; ar_ready = 1'b0; ar_len = 8'd0; ar_size = 3'd0;
    w_valid = 1'b0; w_ready = 1'b0; w_strb = 64'd0;
    r_valid = 1'b0; r_ready = 1'b0; r_last = 1'b0; b_valid = 1'b0; b_ready = 1'b0;
    buf_w_valid = 1'b0; buf_w_ready = 1'b0; buf_r_valid = 1'b0; buf_r_ready = 1'b0;
    backend_busy = 1'b0;
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    #12;
    check("reset_busy", {31'd0, dma_busy}, 32'd0);
    check("reset_err", {31'd0, err}, 32'd0);
    check("reset_aw_done", {31'd0, aw_done}, 32'd0);
    rst = 1'b0;
    step();

    // AW handshake len=3 size=6
    aw_valid = 1'b1; aw_ready = 1'b1; aw_len = 8'd3; aw_size = 3'd6;
    step();
    check("aw_done", {31'd0, aw_done}, 32'd1);
    check("aw_len", {24'd0, aw_len_q}, 32'd3);
    check("aw_size", {29'd0, aw_size_q}, 32'd6);
    check("aw_busy", {31'd0, dma_busy}, 32'd1);
    aw_valid = 1'b0; aw_len = 8'd0; aw_size = 3'd0;
    step();
    check("aw_done_off", {31'd0, aw_done}, 32'd0);
    check("aw_len_off", {24'd0, aw_len_q}, 32'd0);
    check("aw_size_off", {29'd0, aw_size_q}, 32'd0);
    aw_ready = 1'b0;
    b_valid = 1'b1; b_ready = 1'b1;
    step();
    check("b_done", {31'd0, b_done}, 32'd1);
    check("drain_busy", {31'd0, dma_busy}, 32'd0);
    check("drain_err", {31'd0, err}, 32'd0);
    b_valid = 1'b0; b_ready = 1'b0;

    // W beat byte count and stall
    w_valid = 1'b1; w_ready = 1'b1; w_strb = 64'h00FF_0000_0000_000F;
    step();
    check("w_done", {31'd0, w_done}, 32'd1);
    check("w_bytes", {25'd0, nbw}, 32'd12);
    w_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("w_stall", {31'd0, w_stall}, 32'd1);
      check("w_bytes_stall", {25'd0, nbw}, 32'd0);
    end
    w_valid = 1'b0;
    step();
    check("w_stall_end", {31'd0, w_stall}, 32'd0);
    w_strb = 64'hFFFF_FFFF_FFFF_FFFF; w_valid = 1'b1; w_ready = 1'b1;
    step();
    check("w_bytes_full", {25'd0, nbw}, 32'd64);
    w_valid = 1'b0; w_ready = 1'b0;

    // Other stall strobes
    aw_valid = 1'b1; ar_valid = 1'b1; r_valid = 1'b1; buf_w_valid = 1'b1; buf_r_valid = 1'b1;
    step();
    check("stalls", {26'd0, aw_stall, ar_stall, r_stall, buf_w_stall, buf_r_stall, aw_done}, 32'h3E);
    aw_valid = 1'b0; ar_valid = 1'b0; r_valid = 1'b0; buf_w_valid = 1'b0; buf_r_valid = 1'b0;

    // Write accounting: AW, AW, AW+B, B, B
    aw_valid = 1'b1; aw_ready = 1'b1;
    step(); step();
    b_valid = 1'b1; b_ready = 1'b1;
    step();
    check("wacc_aw_b", {30'd0, aw_done, b_done}, 32'd3);
    aw_valid = 1'b0; aw_ready = 1'b0;
    step();
    check("wacc_busy_2", {31'd0, dma_busy}, 32'd1);
    step();
    check("wacc_busy_done", {31'd0, dma_busy}, 32'd0);
    check("wacc_err", {31'd0, err}, 32'd0);
    b_valid = 1'b0; b_ready = 1'b0;

    // Read accounting
    ar_valid = 1'b1; ar_ready = 1'b1; ar_len = 8'd3; ar_size = 3'd6;
    step();
    check("ar_fields", {20'd0, ar_done, ar_len_q, ar_size_q}, {20'd0, 1'b1, 8'd3, 3'd6});
    ar_valid = 1'b0; ar_ready = 1'b0; ar_len = 8'd0; ar_size = 3'd0;
    r_valid = 1'b1; r_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      r_last = (i == 3);
      step();
      check("r_done", {31'd0, r_done}, 32'd1);
      check("r_busy", {31'd0, dma_busy}, (i == 3) ? 32'd0 : 32'd1);
    end
    r_valid = 1'b0; r_ready = 1'b0; r_last = 1'b0;
    step();
    check("r_done_off", {31'd0, r_done}, 32'd0);
    check("r_err", {31'd0, err}, 32'd0);

    // Backend busy alone
    backend_busy = 1'b1;
    step();
    check("backend_busy", {31'd0, dma_busy}, 32'd1);
    backend_busy = 1'b0;
    step();
    check("backend_idle", {31'd0, dma_busy}, 32'd0);

    // Underflow is sticky until clear
    b_valid = 1'b1; b_ready = 1'b1;
    step();
    check("underflow_err", {31'd0, err}, 32'd1);
    b_valid = 1'b0; b_ready = 1'b0;
    step(); step();
    check("err_sticky", {31'd0, err}, 32'd1);
    clear = 1'b1;
    step();
    check("clear_err", {31'd0, err}, 32'd0);
    clear = 1'b0;

    // Saturation: 17 AWs hold at 16, 16 Bs drain it
    aw_valid = 1'b1; aw_ready = 1'b1;
    for (int i = 0; i < 16; i++) step();
    check("sat_no_err", {31'd0, err}, 32'd0);
    step();
    check("sat_err", {31'd0, err}, 32'd1);
    aw_valid = 1'b0; aw_ready = 1'b0;
    b_valid = 1'b1; b_ready = 1'b1;
    for (int i = 0; i < 15; i++) step();
    check("sat_busy_15", {31'd0, dma_busy}, 32'd1);
    step();
    check("sat_busy_16", {31'd0, dma_busy}, 32'd0);
    b_valid = 1'b0; b_ready = 1'b0;
    clear = 1'b1;
    step();
    check("sat_clear", {30'd0, err, dma_busy}, 32'd0);

    // Clear beats a same-cycle AW: strobe emitted but not counted
    aw_valid = 1'b1; aw_ready = 1'b1;
    step();
    check("clear_aw_done", {31'd0, aw_done}, 32'd1);
    check("clear_aw_busy", {31'd0, dma_busy}, 32'd0);
    clear = 1'b0; aw_valid = 1'b0; aw_ready = 1'b0;

    // Reset mid-flight with wr_out=3
    aw_valid = 1'b1; aw_ready = 1'b1;
    step(); step(); step();
    check("pre_rst_busy", {30'd0, aw_done, dma_busy}, 32'd3);
    aw_valid = 1'b0; aw_ready = 1'b0;
    rst = 1'b1;
    #1;
    check("async_rst", {30'd0, aw_done, dma_busy}, 32'd0);
    step();
    rst = 1'b0;
    step();
    b_valid = 1'b1; b_ready = 1'b1;
    step();
    check("post_rst_underflow", {30'd0, b_done, err}, 32'd3);
    b_valid = 1'b0; b_ready = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
